// File: rtl/mem_responder_pkg.sv
// Shared definitions for the processor memory bus responder: command encoding,
// tag sizing, return-entry layout and small helpers for tag and busy-LFSR stepping.
package mem_responder_pkg;

    localparam int XLEN     = 32;
    localparam int DATA_W   = 64;
    localparam int TAG_W    = 4;
    localparam int NUM_TAGS = 15;

    typedef enum logic [1:0] {
        BUS_NONE  = 2'b00,
        BUS_LOAD  = 2'b01,
        BUS_STORE = 2'b10
    } bus_cmd_e;

    typedef struct packed {
        logic              valid;
        logic [TAG_W-1:0]  tag;
        logic [DATA_W-1:0] data;
    } ret_entry_t;

    // Tag 0 means "no response", so the sequence wraps 15 -> 1.
    function automatic logic [TAG_W-1:0] tag_advance(input logic [TAG_W-1:0] tag);
        return (tag == TAG_W'(NUM_TAGS)) ? TAG_W'(1) : tag + TAG_W'(1);
    endfunction

    // Fibonacci form of x^16 + x^14 + x^13 + x^11 + 1.
    function automatic logic [15:0] lfsr_step(input logic [15:0] lfsr);
        return {lfsr[0] ^ lfsr[2] ^ lfsr[3] ^ lfsr[5], lfsr[15:1]};
    endfunction

endpackage

// File: rtl/mem_responder_if.sv
// Processor memory bus: command/address/data from the cache controller and
// response/tag/data back from memory.
interface mem_responder_if;
    import mem_responder_pkg::*;

    logic [1:0]        proc2mem_command;
    logic [XLEN-1:0]   proc2mem_addr;
    logic [DATA_W-1:0] proc2mem_data;
    logic [TAG_W-1:0]  mem2proc_response;
    logic [DATA_W-1:0] mem2proc_data;
    logic [TAG_W-1:0]  mem2proc_tag;

    modport master (
        output proc2mem_command, proc2mem_addr, proc2mem_data,
        input  mem2proc_response, mem2proc_data, mem2proc_tag
    );

    modport slave (
        input  proc2mem_command, proc2mem_addr, proc2mem_data,
        output mem2proc_response, mem2proc_data, mem2proc_tag
    );

endinterface

// File: rtl/mem_return_pipe.sv
// Fixed-latency shift register carrying load returns; the last stage drives the
// bus outputs directly, so invalid entries are kept fully zeroed.
module mem_return_pipe
    import mem_responder_pkg::*;
#(
    parameter int LATENCY = 4
) (
    input  logic       clock,
    input  logic       reset_n,
    input  ret_entry_t ret_in,
    output ret_entry_t ret_out
);

    ret_entry_t ret_p [LATENCY];

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            for (int i = 0; i < LATENCY; i++) ret_p[i] <= '0;
        end else begin
            ret_p[0] <= ret_in;
            for (int i = 1; i < LATENCY; i++) ret_p[i] <= ret_p[i-1];
        end
    end

    assign ret_out = ret_p[LATENCY-1];

endmodule

// File: rtl/mem_responder.sv
// Memory-side responder: tag allocation, backing storage and load-return timing.
// Optional MEM_BUSY_EN adds LFSR-driven busy cycles that withhold acceptance.
module mem_responder
    import mem_responder_pkg::*;
#(
    parameter int LATENCY   = 4,
    parameter int MEM_DEPTH = 1024
) (
    input logic            clock,
    input logic            reset_n,
    mem_responder_if.slave bus
);

    localparam int IDX_W = $clog2(MEM_DEPTH);

    logic [DATA_W-1:0] mem [MEM_DEPTH];
    logic [TAG_W-1:0]  next_tag;
    logic [TAG_W-1:0]  response;
    logic              busy;
    logic              is_load;
    logic              is_store;
    logic              accept;
    logic              in_range;
    logic [IDX_W-1:0]  idx;
    logic [DATA_W-1:0] rd_data;
    ret_entry_t        ret_in;
    ret_entry_t        ret_out;
    logic              unused_bits;

    assign is_load  = (bus.proc2mem_command == BUS_LOAD);
    assign is_store = (bus.proc2mem_command == BUS_STORE);
    assign idx      = bus.proc2mem_addr[3 +: IDX_W];
    assign in_range = ((bus.proc2mem_addr >> (3 + IDX_W)) == '0);
    assign rd_data  = in_range ? mem[idx] : '0;

    always_comb begin
        response = '0;
        if (reset_n && (is_load || is_store) && !busy) response = next_tag;
    end

    assign bus.mem2proc_response = response;
    assign accept = (response != '0);

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            next_tag <= TAG_W'(1);
        end else if (accept) begin
            next_tag <= tag_advance(next_tag);
        end
    end

    // Storage is deliberately left out of reset.
    always_ff @(posedge clock) begin
        if (accept && is_store && in_range) mem[idx] <= bus.proc2mem_data;
    end

`ifdef MEM_BUSY_EN
    logic [15:0] lfsr;

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) lfsr <= 16'hACE1;
        else          lfsr <= lfsr_step(lfsr);
    end

    assign busy = lfsr[0];
`else
    assign busy = 1'b0;
`endif

    always_comb begin
        ret_in = '0;
        if (accept && is_load) begin
            ret_in.valid = 1'b1;
            ret_in.tag   = next_tag;
            ret_in.data  = rd_data;
        end
    end

    // Return stages: accept edge through cycle T+LATENCY
    mem_return_pipe #(.LATENCY(LATENCY)) u_return_pipe (
        .clock   (clock),
        .reset_n (reset_n),
        .ret_in  (ret_in),
        .ret_out (ret_out)
    );

    assign bus.mem2proc_tag  = ret_out.tag;
    assign bus.mem2proc_data = ret_out.data;

    assign unused_bits = ^{bus.proc2mem_addr[2:0], ret_out.valid};

endmodule
